vector_checker: RTL and testbench
=================================

VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 Parameter WIDTH, default 10, bit width of one observed/expected vector.
REQ-002 Parameter DEPTH, default 10, number of expected vectors stored.
REQ-003 Parameter CNT_WIDTH, default 32, width of vecnum and errors counters.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 load_en  in  1  write expected vector into memory this cycle.
REQ-008 load_addr  in  clog2(DEPTH)  expected-memory write index.
REQ-009 load_data  in  WIDTH  expected vector value.
REQ-010 start  in  1  one-cycle request to begin a check run.
REQ-011 obs_valid  in  1  obs_data holds a DUT response to be checked this cycle.
REQ-012 obs_data  in  WIDTH  observed DUT response vector.
REQ-013 busy  out  1  high while in RUN.
REQ-014 done  out  1  high while in DONE.
REQ-015 mismatch  out  1  one-cycle pulse, registered, for each failing compare.
REQ-016 vecnum  out  CNT_WIDTH  count of vectors compared in the current run.
REQ-017 errors  out  CNT_WIDTH  count of failing compares in the current run.
REQ-018 first_err_idx  out  CNT_WIDTH  vecnum of first failing compare; valid when first_err_vld.
REQ-019 first_err_vld  out  1  at least one mismatch recorded this run.
REQ-020 pass  out  1  done high and errors zero.

Function
REQ-021 FSM states SHALL be IDLE, RUN, DONE.
REQ-022 IDLE -> RUN on start; vecnum, errors, first_err_idx, first_err_vld, mismatch cleared that same edge.
REQ-023 DONE -> RUN on start, same clearing as REQ-022; start ignored in RUN.
REQ-024 In RUN, each cycle with obs_valid SHALL compare obs_data to mem[vecnum] and increment vecnum; cycles without obs_valid change nothing.
REQ-025 Compare result SHALL appear one cycle after the sampled obs_valid: mismatch pulse, errors+1, and first_err_idx/first_err_vld set only on first failure.
REQ-026 RUN -> DONE on the edge that accepts the compare with vecnum == DEPTH-1; no further compares in DONE.
REQ-027 errors SHALL saturate at all-ones, never wrap.
REQ-028 load_en SHALL write memory only in IDLE or DONE; ignored in RUN.
REQ-029 load_en and start in the same cycle: write performed, run starts; write is visible to compare index 0 only from the next cycle.
REQ-030 obs_valid in IDLE or DONE SHALL be ignored.
REQ-031 Expected memory contents SHALL NOT be cleared by reset.

Reset
REQ-032 rst low SHALL force, asynchronously: state IDLE, busy 0, done 0, mismatch 0, vecnum 0, errors 0, first_err_idx 0, first_err_vld 0, pass 0.
REQ-033 rst asserted mid-run SHALL abort the run; after release the block waits in IDLE for start.

Structure
REQ-034 State encodings and default WIDTH/DEPTH/CNT_WIDTH SHALL live in the shared header include, reused by the stimulus-side blocks.
REQ-035 Expected storage SHALL be a sub-module vector_checker_mem: one write port, one asynchronous read port, DEPTH x WIDTH.
REQ-036 FSM, counters and compare logic SHALL reside in vector_checker.

Verification
REQ-037 Load 10 vectors, start, feed 10 matching obs_data -> done=1, pass=1, vecnum=10, errors=0, no mismatch pulse.
REQ-038 Same run but vector 3 and 7 corrupted -> mismatch pulses at compares 3 and 7, errors=2, first_err_idx=3, pass=0.
REQ-039 obs_valid toggled 1-0-1 during run -> vecnum advances only on valid cycles; done after 10th valid.
REQ-040 Assert rst at vecnum=5 -> all outputs zero immediately; new start reruns from vecnum 0 with memory intact, pass=1.
REQ-041 load_en during RUN writes wrong value to addr 2 -> ignored, run passes; start in DONE clears counters and reruns.
REQ-042 CNT_WIDTH=2, DEPTH=10, all vectors mismatch -> errors saturates at 3.

Source files
------------

// File: rtl/vector_checker_pkg.sv
// Shared definitions for the vector checker: default sizing and FSM state encoding.
package vector_checker_pkg;

    localparam int DEF_WIDTH     = 10;
    localparam int DEF_DEPTH     = 10;
    localparam int DEF_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Saturation flag helper: true when a counter value is all-ones.
    function automatic logic all_ones(input logic [63:0] value, input int bits);
        logic result;
        result = 1'b1;
        for (int i = 0; i < bits; i++) begin
            if (!value[i]) begin
                result = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vector_checker_mem.sv
// Expected-vector storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not touched by reset so vectors survive an aborted run.
module vector_checker_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: out-of-range addresses are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (we && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read; out-of-range index returns zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < DEPTH) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/vector_checker.sv
// Vector checker: compares a stream of observed vectors against a preloaded
// expected table, counting vectors and errors and recording the first failure.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       start,
    input  logic                       obs_valid,
    input  logic [WIDTH-1:0]           obs_data,
    output logic                       busy,
    output logic                       done,
    output logic                       mismatch,
    output logic [CNT_WIDTH-1:0]       vecnum,
    output logic [CNT_WIDTH-1:0]       errors,
    output logic [CNT_WIDTH-1:0]       first_err_idx,
    output logic                       first_err_vld,
    output logic                       pass
);

    localparam int AW = $clog2(DEPTH);

    state_t               state_reg, state_next;

    // Memory index is kept separate from vecnum so a narrow CNT_WIDTH
    // cannot stop the run from reaching the last table entry.
    logic [AW-1:0]        idx_reg;
    logic [CNT_WIDTH-1:0] vecnum_reg;
    logic [CNT_WIDTH-1:0] errors_reg;
    logic [CNT_WIDTH-1:0] first_err_idx_reg;
    logic                 first_err_vld_reg;
    logic                 mismatch_reg;

    logic [WIDTH-1:0]     exp_data;
    logic                 mem_we;
    logic                 run_start;
    logic                 accept;
    logic                 cmp_fail;
    logic                 last_vec;
    logic                 errors_full;

    // Table writes are locked out while a run is reading it.
    assign mem_we = load_en && (state_reg != ST_RUN);

    vector_checker_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (idx_reg),
        .rd_data (exp_data)
    );

    assign last_vec    = (idx_reg == AW'(DEPTH - 1));
    assign cmp_fail    = accept && (obs_data != exp_data);
    assign errors_full = all_ones(64'(errors_reg), CNT_WIDTH);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        run_start  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    run_start  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                accept = obs_valid;
                if (obs_valid && last_vec) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    run_start  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counters and compare result; the result registers on the accepting edge
    // so it is seen in the cycle after obs_valid was sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg           <= '0;
            vecnum_reg        <= '0;
            errors_reg        <= '0;
            first_err_idx_reg <= '0;
            first_err_vld_reg <= 1'b0;
            mismatch_reg      <= 1'b0;
        end else if (run_start) begin
            idx_reg           <= '0;
            vecnum_reg        <= '0;
            errors_reg        <= '0;
            first_err_idx_reg <= '0;
            first_err_vld_reg <= 1'b0;
            mismatch_reg      <= 1'b0;
        end else begin
            mismatch_reg <= cmp_fail;
            if (accept) begin
                idx_reg    <= idx_reg + AW'(1);
                vecnum_reg <= vecnum_reg + CNT_WIDTH'(1);
            end
            if (cmp_fail) begin
                if (!errors_full) begin
                    errors_reg <= errors_reg + CNT_WIDTH'(1);
                end
                if (!first_err_vld_reg) begin
                    first_err_idx_reg <= vecnum_reg;
                    first_err_vld_reg <= 1'b1;
                end
            end
        end
    end

    assign mismatch      = mismatch_reg;
    assign vecnum        = vecnum_reg;
    assign errors        = errors_reg;
    assign first_err_idx = first_err_idx_reg;
    assign first_err_vld = first_err_vld_reg;
    assign pass          = done && (errors_reg == '0);

endmodule

// File: tb/tb_vector_checker.sv
// Randomized scoreboard bench for vector_checker; a second instance with a
// 2-bit counter width shares the stimulus to exercise error saturation.
module tb_vector_checker;
    import vector_checker_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int D  = DEF_DEPTH;
    localparam int CW = DEF_CNT_WIDTH;
    localparam int AW = $clog2(D);

    logic          clk;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic          start;
    logic          obs_valid;
    logic [W-1:0]  obs_data;

    logic          busy, done, mismatch, first_err_vld, pass;
    logic [CW-1:0] vecnum, errors, first_err_idx;

    logic          s_busy, s_done, s_mismatch, s_first_err_vld, s_pass;
    logic [1:0]    s_vecnum, s_errors, s_first_err_idx;

    vector_checker #(.WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .obs_valid(obs_valid),
        .obs_data(obs_data), .busy(busy), .done(done), .mismatch(mismatch),
        .vecnum(vecnum), .errors(errors), .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld), .pass(pass)
    );

    vector_checker #(.WIDTH(W), .DEPTH(D), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .obs_valid(obs_valid),
        .obs_data(obs_data), .busy(s_busy), .done(s_done), .mismatch(s_mismatch),
        .vecnum(s_vecnum), .errors(s_errors), .first_err_idx(s_first_err_idx),
        .first_err_vld(s_first_err_vld), .pass(s_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected table plus run bookkeeping.
    logic [W-1:0] exp_mem [D];
    bit          m_running;
    bit          m_finished;
    int unsigned m_cnt;
    int unsigned m_err;
    int unsigned m_fei;
    bit          m_fev;

    typedef struct {
        bit          fail;
        int unsigned vecnum;
        int unsigned errors;
        int unsigned fei;
        bit          fev;
        bit          done;
    } exp_t;

    exp_t sb[$];

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 3) ? 3 : v;
    endfunction

    // One stimulus cycle: drive at negedge, predict the effect of the next posedge.
    task automatic cycle(input bit le, input int la, input logic [W-1:0] ld,
                         input bit st, input bit ov, input logic [W-1:0] od);
        exp_t e;
        bit   was_run;
        @(negedge clk);
        load_en   = le;
        load_addr = la[AW-1:0];
        load_data = ld;
        start     = st;
        obs_valid = ov;
        obs_data  = od;
        was_run   = m_running;
        if (was_run && ov) begin
            e.fail = (od != exp_mem[m_cnt]);
            if (e.fail) begin
                if (!m_fev) begin
                    m_fei = m_cnt;
                    m_fev = 1'b1;
                end
                m_err++;
            end
            m_cnt++;
            if (m_cnt == D) begin
                m_running  = 1'b0;
                m_finished = 1'b1;
            end
            e.vecnum = m_cnt;
            e.errors = m_err;
            e.fei    = m_fei;
            e.fev    = m_fev;
            e.done   = m_finished;
            sb.push_back(e);
        end else if (!was_run && st) begin
            m_running  = 1'b1;
            m_finished = 1'b0;
            m_cnt      = 0;
            m_err      = 0;
            m_fei      = 0;
            m_fev      = 1'b0;
        end
        if (!was_run && le) begin
            exp_mem[la] = ld;
        end
    endtask

    task automatic end_check(input string tag);
        chk({tag, "_done"},    longint'(done), longint'(m_finished));
        chk({tag, "_busy"},    longint'(busy), longint'(m_running));
        chk({tag, "_pass"},    longint'(pass), longint'(m_finished && m_err == 0));
        chk({tag, "_vecnum"},  longint'(vecnum), longint'(m_cnt));
        chk({tag, "_errors"},  longint'(errors), longint'(m_err));
        chk({tag, "_fev"},     longint'(first_err_vld), longint'(m_fev));
        chk({tag, "_fei"},     longint'(first_err_idx), longint'(m_fei));
        chk({tag, "_sat_err"}, longint'(s_errors), longint'(sat3(m_err)));
        chk({tag, "_sat_vn"},  longint'(s_vecnum), longint'(m_cnt % 4));
        chk({tag, "_sat_pass"}, longint'(s_pass), longint'(m_finished && m_err == 0));
        chk({tag, "_sb_empty"}, longint'(sb.size()), 0);
        $display("run %s: vecnum=%0d errors=%0d sat_errors=%0d first_err=%0d/%0d pass=%0d",
                 tag, vecnum, errors, s_errors, first_err_vld, first_err_idx, pass);
    endtask

    task automatic load_all();
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, i, W'($urandom), 1'b0, 1'b0, '0);
        end
    endtask

    // Start a run and feed observed vectors until the model sees it complete.
    task automatic run_vectors(input string tag, input bit [D-1:0] bad, input int gap_pct,
                               input bit noise, input bit load_with_start);
        logic [W-1:0] od;
        logic [W-1:0] one;
        bit           ov;
        int           guard;
        one   = 1;
        guard = 0;
        if (load_with_start) begin
            cycle(1'b1, 0, W'($urandom), 1'b1, 1'b0, '0);
        end else begin
            cycle(1'b0, 0, '0, 1'b1, 1'b0, '0);
        end
        while (m_running && guard < 2000) begin
            guard++;
            ov = ($urandom_range(99) >= gap_pct);
            od = exp_mem[m_cnt];
            if (bad[m_cnt]) begin
                od = od ^ (one << $urandom_range(W - 1));
            end
            cycle(noise && ($urandom_range(2) == 0), 2, W'($urandom),
                  noise && ($urandom_range(3) == 0), ov, od);
        end
        repeat (3) cycle(1'b0, 0, '0, 1'b0, noise && ($urandom_range(1) == 0), W'($urandom));
        end_check(tag);
    endtask

    // Monitor: a compare result is presented when vecnum advances or mismatch pulses.
    initial begin
        logic [CW-1:0] last_vn;
        exp_t          e;
        last_vn = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && (((vecnum != last_vn) && (vecnum != '0)) || mismatch)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", longint'(vecnum), longint'(last_vn));
                end else begin
                    e = sb.pop_front();
                    chk("mismatch",     longint'(mismatch), longint'(e.fail));
                    chk("vecnum",       longint'(vecnum), longint'(e.vecnum));
                    chk("errors",       longint'(errors), longint'(e.errors));
                    chk("first_vld",    longint'(first_err_vld), longint'(e.fev));
                    chk("first_idx",    longint'(first_err_idx), longint'(e.fei));
                    chk("done",         longint'(done), longint'(e.done));
                    chk("sat_mismatch", longint'(s_mismatch), longint'(e.fail));
                    chk("sat_errors",   longint'(s_errors), longint'(sat3(e.errors)));
                    chk("sat_vecnum",   longint'(s_vecnum), longint'(e.vecnum % 4));
                    chk("sat_first",    longint'(s_first_err_idx), longint'(e.fei % 4));
                    $display("compare %0d: fail=%0d mismatch=%0d errors=%0d done=%0d",
                             e.vecnum - 1, e.fail, mismatch, errors, done);
                end
            end
            last_vn = vecnum;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   longint'(busy), 0);
        chk({tag, "_done"},   longint'(done), 0);
        chk({tag, "_mism"},   longint'(mismatch), 0);
        chk({tag, "_vecnum"}, longint'(vecnum), 0);
        chk({tag, "_errors"}, longint'(errors), 0);
        chk({tag, "_fei"},    longint'(first_err_idx), 0);
        chk({tag, "_fev"},    longint'(first_err_vld), 0);
        chk({tag, "_pass"},   longint'(pass), 0);
        chk({tag, "_sat_err"}, longint'(s_errors), 0);
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; obs_valid = 1'b0; obs_data = '0;
        m_running = 1'b0; m_finished = 1'b0; m_cnt = 0; m_err = 0; m_fei = 0; m_fev = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        load_all();
        run_vectors("all_match", '0, 0, 1'b0, 1'b0);
        run_vectors("bad_3_7", 10'b0010001000, 0, 1'b0, 1'b0);
        run_vectors("gaps", '0, 50, 1'b0, 1'b0);
        run_vectors("load_in_run", '0, 20, 1'b1, 1'b0);
        run_vectors("load_with_start", '0, 10, 1'b0, 1'b1);

        // Abort a run part way through with reset, then rerun from the retained table.
        cycle(1'b0, 0, '0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 0, '0, 1'b0, 1'b1, exp_mem[m_cnt]);
        end
        cycle(1'b0, 0, '0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        chk("pre_rst_vecnum", longint'(vecnum), 5);
        rst = 1'b0;
        #1;
        check_zero("mid_rst");
        m_running = 1'b0; m_finished = 1'b0; m_cnt = 0; m_err = 0; m_fei = 0; m_fev = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cycle(1'b0, 0, '0, 1'b0, 1'b1, '0);
        check_zero("idle_after_rst");
        run_vectors("after_rst", '0, 0, 1'b0, 1'b0);

        run_vectors("all_bad", '1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) begin
                load_all();
            end
            run_vectors($sformatf("random_%0d", r), D'($urandom), $urandom_range(60),
                        1'b1, bit'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
